// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Hits answer one cycle after the request registers; misses refill a full line.
`timescale 1ns/1ps
module dcache_ctrl #(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_re,
   input  logic [3:0]  cpu_we,
   input  logic [31:0] cpu_din,
   output logic [31:0] cpu_dout,
   output logic        stall,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_rnw,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_data,
   output logic [3:0]  mem_req_mask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
);
   // state       | meaning
   // IDLE        | registered request is looked up / store issued
   // REFILL_REQ  | line read request outstanding
   // REFILL_DATA | collecting refill beats
   // RESPOND     | refilled word returned, CPU released
   // WRITE_REQ   | store waiting for memory acceptance
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - OFF_W - IDX_W;

   typedef enum logic [2:0] {IDLE, REFILL_REQ, REFILL_DATA, RESPOND, WRITE_REQ} state_t;

   state_t           state_q, state_d;
   logic             req_re_q, req_re_d;
   logic [3:0]       req_we_q, req_we_d;
   logic [29:0]      req_waddr_q, req_waddr_d;
   logic [31:0]      req_din_q, req_din_d;
   logic [OFF_W-1:0] cnt_q, cnt_d;
   logic [31:0]      dout_q, dout_d;
   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q [LINES];
   logic [31:0]      data_q [LINES][LINE_WORDS];

   logic [OFF_W-1:0] req_off;
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic             hit;
   logic [31:0]      cur_word, merged;
   logic             beat_wr, merge_wr, tag_wr, load_done;
   logic             addr_lsb_unused;

   assign addr_lsb_unused = ^cpu_addr[1:0];
   assign req_off  = req_waddr_q[OFF_W-1:0];
   assign req_idx  = req_waddr_q[OFF_W+IDX_W-1:OFF_W];
   assign req_tag  = req_waddr_q[29:OFF_W+IDX_W];
   assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign cur_word = data_q[req_idx][req_off];
   assign cpu_dout = load_done ? cur_word : dout_q;

   always_comb begin
      merged = cur_word;
      for (int b = 0; b < 4; b++) begin
         if (req_we_q[b]) merged[8*b +: 8] = req_din_q[8*b +: 8];
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      dout_d        = dout_q;
      valid_d       = valid_q;
      req_re_d      = req_re_q;
      req_we_d      = req_we_q;
      req_waddr_d   = req_waddr_q;
      req_din_d     = req_din_q;
      stall         = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_rnw   = 1'b0;
      mem_req_addr  = '0;
      mem_req_data  = '0;
      mem_req_mask  = '0;
      beat_wr       = 1'b0;
      merge_wr      = 1'b0;
      tag_wr        = 1'b0;
      load_done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_re_q) begin
               if (hit) begin
                  load_done = 1'b1;
               end else begin
                  stall   = 1'b1;
                  state_d = REFILL_REQ;
               end
            end else if (|req_we_q) begin
               mem_req_valid = 1'b1;
               mem_req_addr  = {req_waddr_q, 2'b00};
               mem_req_data  = req_din_q;
               mem_req_mask  = req_we_q;
               if (mem_req_ready) begin
                  merge_wr = hit;
               end else begin
                  stall   = 1'b1;
                  state_d = WRITE_REQ;
               end
            end
         end
         REFILL_REQ: begin
            stall         = 1'b1;
            mem_req_valid = 1'b1;
            mem_req_rnw   = 1'b1;
            mem_req_addr  = {req_waddr_q[29:OFF_W], {(OFF_W+2){1'b0}}};
            if (mem_req_ready) begin
               cnt_d   = '0;
               state_d = REFILL_DATA;
            end
         end
         REFILL_DATA: begin
            stall = 1'b1;
            if (mem_resp_valid) begin
               beat_wr = 1'b1;
               cnt_d   = cnt_q + OFF_W'(1);
               if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                  tag_wr           = 1'b1;
                  valid_d[req_idx] = 1'b1;
                  state_d          = RESPOND;
               end
            end
         end
         RESPOND: begin
            load_done = 1'b1;
            state_d   = IDLE;
         end
         WRITE_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {req_waddr_q, 2'b00};
            mem_req_data  = req_din_q;
            mem_req_mask  = req_we_q;
            stall         = ~mem_req_ready;
            if (mem_req_ready) begin
               merge_wr = hit;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load_done) dout_d = cur_word;
      // The request register only advances when the CPU is not held.
      if (!stall) begin
         req_re_d    = cpu_re;
         req_we_d    = cpu_we;
         req_waddr_d = cpu_addr[31:2];
         req_din_d   = cpu_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dout_q      <= '0;
         valid_q     <= '0;
         req_re_q    <= 1'b0;
         req_we_q    <= '0;
         req_waddr_q <= '0;
         req_din_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         req_re_q    <= req_re_d;
         req_we_q    <= req_we_d;
         req_waddr_q <= req_waddr_d;
         req_din_q   <= req_din_d;
      end
   end

   always_ff @(posedge clk) begin
      if (beat_wr)  data_q[req_idx][cnt_q]   <= mem_resp_data;
      if (merge_wr) data_q[req_idx][req_off] <= merged;
      if (tag_wr)   tag_q[req_idx]           <= req_tag;
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a flat memory plus a tag table predict every
// load value and every memory request; a monitor compares as the DUT presents them.
`timescale 1ns/1ps
module tb_dcache_ctrl;
   localparam int LINES = 64;
   localparam int LW    = 4;
   localparam int OFFB  = 2 + $clog2(LW);
   localparam int IDXB  = $clog2(LINES);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cpu_addr = '0;
   logic        cpu_re = 1'b0;
   logic [3:0]  cpu_we = '0;
   logic [31:0] cpu_din = '0;
   logic [31:0] cpu_dout;
   logic        stall;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_rnw;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic [3:0]  mem_req_mask;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;

   dcache_ctrl #(.LINES(LINES), .LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .stall(stall),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rnw;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } mreq_t;

   int          n_tests = 0;
   int          n_fail = 0;
   mreq_t       exp_mem[$];
   logic [31:0] exp_load[$];
   logic [31:0] ref_mem [bit [31:0]];
   logic [31:0] env_mem [bit [31:0]];
   bit          ref_valid [LINES];
   logic [31:0] ref_tag [LINES];
   int          ready_mode = 1;
   int          low_budget = 0;
   int          stall_cnt = 0;
   int          mem_hs = 0;
   int          beats_cur = 0;
   bit          mon_inflight = 0;
   logic [31:0] last_dout = '0;
   bit          hold_pend = 0;
   mreq_t       held;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] env_rd(input logic [31:0] a);
      if (env_mem.exists(a)) return env_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Reference: the cache is transparent, so a load returns the memory word;
   // only a tag table is needed to know when a line read must appear.
   task automatic predict(input bit re, input logic [3:0] we, input logic [31:0] a,
                          input logic [31:0] d);
      int    idx;
      logic [31:0] tag;
      logic [31:0] wa;
      mreq_t r;
      idx = int'((a >> OFFB) % LINES);
      tag = a >> (OFFB + IDXB);
      wa  = a & ~32'h3;
      if (re) begin
         if (!(ref_valid[idx] && ref_tag[idx] == tag)) begin
            r.rnw = 1'b1; r.addr = a & ~32'(LW * 4 - 1); r.data = '0; r.mask = '0;
            exp_mem.push_back(r);
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
         end
         exp_load.push_back(ref_rd(wa));
      end else if (we != 4'b0) begin
         r.rnw = 1'b0; r.addr = wa; r.data = d; r.mask = we;
         exp_mem.push_back(r);
         ref_mem[wa] = merge(ref_rd(wa), d, we);
      end
   endtask

   task automatic issue(input bit re, input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] d);
      int n;
      bit acc;
      n = 0;
      acc = 0;
      predict(re, we, a, d);
      cpu_re = re; cpu_we = we; cpu_addr = a; cpu_din = d;
      while (!acc && n < 1000) begin
         @(negedge clk);
         acc = !stall;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) check("accept_timeout", stall, 0);
      cpu_re = 1'b0; cpu_we = 4'b0; cpu_addr = $urandom; cpu_din = $urandom;
   endtask

   task automatic settle();
      int n;
      n = 0;
      @(negedge clk);
      while (stall && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("settle_timeout", stall, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (low_budget > 0)       mem_req_ready = 1'b0;
         else if (ready_mode == 1) mem_req_ready = 1'b1;
         else                      mem_req_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Backing memory: accepts writes, streams line reads with optional gaps.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && mem_req_valid && mem_req_ready) begin
            if (!mem_req_rnw) begin
               env_mem[{mem_req_addr[31:2], 2'b00}] =
                  merge(env_rd({mem_req_addr[31:2], 2'b00}), mem_req_data, mem_req_mask);
            end else begin : burst
               logic [31:0] base;
               bit          abort;
               int          gap;
               base = mem_req_addr;
               abort = 0;
               beats_cur = 0;
               @(posedge clk);
               #1;
               for (int w = 0; w < LW && !abort; w++) begin
                  gap = (ready_mode == 1) ? 0 : $urandom_range(0, 2);
                  for (int g = 0; g < gap && !abort; g++) begin
                     @(posedge clk);
                     #1;
                     if (rst) abort = 1;
                  end
                  if (!abort) begin
                     mem_resp_valid = 1'b1;
                     mem_resp_data  = env_rd(base + 32'(4 * w));
                     @(posedge clk);
                     #1;
                     mem_resp_valid = 1'b0;
                     if (rst) abort = 1;
                     else     beats_cur++;
                  end
               end
               mem_resp_valid = 1'b0;
            end
         end
      end
   end

   // Monitor: memory requests, request stability, load results, dout hold.
   initial begin
      mreq_t       e;
      logic [31:0] ld;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_inflight = 0;
            hold_pend = 0;
         end else begin
            if (stall) stall_cnt++;
            if (mem_req_valid && !mem_req_ready && low_budget > 0) low_budget--;
            if (hold_pend) begin
               check("req_hold_valid", mem_req_valid, 1);
               check("req_hold_rnw", mem_req_rnw, held.rnw);
               check("req_hold_addr", mem_req_addr, held.addr);
               check("req_hold_data", mem_req_data, held.data);
               check("req_hold_mask", mem_req_mask, held.mask);
            end
            hold_pend = mem_req_valid && !mem_req_ready;
            held.rnw = mem_req_rnw; held.addr = mem_req_addr;
            held.data = mem_req_data; held.mask = mem_req_mask;
            if (mem_req_valid && mem_req_ready) begin
               mem_hs++;
               check("mem_req_expected", exp_mem.size() != 0, 1);
               if (exp_mem.size() != 0) begin
                  e = exp_mem.pop_front();
                  check("mem_req_rnw", mem_req_rnw, e.rnw);
                  check("mem_req_addr", mem_req_addr, e.addr);
                  if (!e.rnw) begin
                     check("mem_req_data", mem_req_data, e.data);
                     check("mem_req_mask", mem_req_mask, e.mask);
                  end
               end
            end
            if (!stall && mon_inflight) begin
               check("load_expected", exp_load.size() != 0, 1);
               if (exp_load.size() != 0) begin
                  ld = exp_load.pop_front();
                  check("load_data", cpu_dout, ld);
                  last_dout = ld;
               end
            end else begin
               check("dout_hold", cpu_dout, last_dout);
            end
            if (!stall) mon_inflight = cpu_re;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int          s0, h0, n, op;
      logic [31:0] a;
      logic [3:0]  m;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_req_rnw", mem_req_rnw, 0);
      check("rst_req_addr", mem_req_addr, 0);
      check("rst_req_data", mem_req_data, 0);
      check("rst_req_mask", mem_req_mask, 0);
      check("rst_dout", cpu_dout, 0);
      @(posedge clk);
      #1;

      for (int w = 0; w < LW; w++) begin
         ref_mem[32'h1000_0000 + 32'(4 * w)] = 32'hA0 + 32'(w);
         env_mem[32'h1000_0000 + 32'(4 * w)] = 32'hA0 + 32'(w);
      end
      ready_mode = 1;

      // Cold miss then a hit in the refilled line.
      s0 = stall_cnt; h0 = mem_hs;
      issue(1, 4'b0, 32'h1000_0008, 0);
      issue(1, 4'b0, 32'h1000_000C, 0);
      settle();
      check("t1_stall_cycles", stall_cnt - s0, 2 + LW);
      check("t1_mem_reqs", mem_hs - h0, 1);

      // Store hit with ready high, then reload the merged word.
      s0 = stall_cnt; h0 = mem_hs;
      issue(0, 4'b0011, 32'h1000_0004, 32'hDEAD_BEEF);
      issue(1, 4'b0, 32'h1000_0004, 0);
      settle();
      check("t3_stall_cycles", stall_cnt - s0, 0);
      check("t3_mem_reqs", mem_hs - h0, 1);
      check("t3_load_merged", cpu_dout, 32'h0000_BEEF);

      // Store miss held off by memory for three cycles; no allocation.
      s0 = stall_cnt; h0 = mem_hs;
      low_budget = 3;
      issue(0, 4'b1111, 32'h1000_0400, 32'h1234_5678);
      settle();
      check("t4_stall_cycles", stall_cnt - s0, 3);
      check("t4_mem_reqs", mem_hs - h0, 1);
      h0 = mem_hs;
      issue(1, 4'b0, 32'h1000_0400, 0);
      settle();
      check("t4_no_alloc_refill", mem_hs - h0, 1);

      // Conflicting tags on one index evict each other.
      h0 = mem_hs;
      issue(1, 4'b0, 32'h1000_0008, 0);
      issue(1, 4'b0, 32'h1000_0408, 0);
      issue(1, 4'b0, 32'h1000_0008, 0);
      settle();
      check("t5_mem_reqs", mem_hs - h0, 3);

      // Reset in the middle of a refill.
      beats_cur = 0;
      issue(1, 4'b0, 32'h1000_0408, 0);
      n = 0;
      while (beats_cur < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t6_two_beats_seen", beats_cur, 2);
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      exp_load.delete();
      exp_mem.delete();
      mon_inflight = 0;
      hold_pend = 0;
      last_dout = '0;
      low_budget = 0;
      for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
      @(negedge clk);
      check("t6_stall_after_rst", stall, 0);
      check("t6_dout_after_rst", cpu_dout, 0);
      @(posedge clk);
      #2;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hBAD0_BAD0;
      @(posedge clk);
      #2;
      mem_resp_valid = 1'b0;
      h0 = mem_hs;
      issue(1, 4'b0, 32'h1000_0408, 0);
      settle();
      check("t6_refill_again", mem_hs - h0, 1);

      // Randomized mix over a small address pool with random memory timing.
      ready_mode = 0;
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 9);
         a = 32'h2000_0000 | (32'($urandom_range(0, 3)) << (OFFB + IDXB))
                           | (32'($urandom_range(0, 7)) << OFFB)
                           | (32'($urandom_range(0, LW - 1)) << 2);
         if (op < 5) begin
            issue(1, 4'b0, a, 0);
         end else if (op < 9) begin
            m = 4'($urandom_range(1, 15));
            issue(0, m, a, $urandom);
         end else begin
            @(posedge clk);
            #1;
         end
      end
      settle();
      repeat (4) @(posedge clk);
      #1;
      check("end_loads_drained", exp_load.size(), 0);
      check("end_memreqs_drained", exp_mem.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits directly downstream of the CPU's data-memory port. It consumes the CPU address, read enable, byte write enables and write data, and returns load data plus the global stall.
- Misses and all stores go to a backing-memory request/response interface.
- Hits return data with block-RAM timing: data on the cycle after the address is presented.

Parameters:
- LINES, 64, number of cache lines (power of two).
- LINE_WORDS, 4, 32-bit words per line (power of two, at least 2).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  32  byte address; word-aligned bits [1:0] are ignored.
- cpu_re  in  1  load request.
- cpu_we  in  4  byte write enables; nonzero means store. Never asserted together with cpu_re.
- cpu_din  in  32  store data, already lane-aligned.
- cpu_dout  out  32  load data.
- stall  out  1  CPU must hold its request and pipeline while high.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request when valid&ready.
- mem_req_rnw  out  1  1 = line read (burst), 0 = single-word write.
- mem_req_addr  out  32  line-aligned for reads; word address for writes.
- mem_req_data  out  32  store data.
- mem_req_mask  out  4  store byte enables.
- mem_resp_valid  in  1  one read beat valid.
- mem_resp_data  in  32  read beat; beats arrive in ascending word order.

Behaviour:
- Address split: offset = addr[log2(LINE_WORDS)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: data array, tag array, and per-line valid bits.
- Pipeline timing:
  - Cycle N: the request is registered when stall=0.
  - Cycle N+1: tag compare on the registered request.
  - stall is combinational in N+1, so the CPU re-presents the same request while stalled.
- States: IDLE, REFILL_REQ, REFILL_DATA, RESPOND, WRITE_REQ.
- IDLE, registered load:
  - Hit (valid & tag match): cpu_dout = stored word in N+1, stall=0.
  - Miss: go to REFILL_REQ, stall=1.
- REFILL_REQ:
  - mem_req_valid=1, rnw=1, addr = {tag,index,offset 0,2'b00}.
  - On ready, go to REFILL_DATA with beat counter = 0.
- REFILL_DATA:
  - Each mem_resp_valid writes beat into word[counter] and increments the counter.
  - After beat LINE_WORDS-1: write tag, set valid, go to RESPOND.
  - Non-beat cycles hold the counter.
- RESPOND:
  - cpu_dout = requested word, stall=0 for exactly this cycle.
  - Next state IDLE; the CPU advances and the next request is registered this cycle.
- Registered store:
  - In N+1 go to WRITE_REQ behaviour: mem_req_valid=1, rnw=0, addr = word address, data/mask from the request.
  - stall = ~mem_req_ready.
  - On acceptance: if hit, merge enabled bytes into the cached word; if miss, no allocate. Return to IDLE.
  - A store accepted with ready=1 in N+1 costs zero stall cycles.
- cpu_dout:
  - Holds its last value when no load completes.
  - Reset value 0.
  - Loads never return data bypassed from a store in the same cycle; stores complete before the next request registers.
- No request (re=0, we=0): stays IDLE, stall=0, mem_req_valid=0.
- Reset outputs: stall=0, mem_req_valid=0, mem_req_rnw=0, mem_req_addr=0, mem_req_data=0, mem_req_mask=0, cpu_dout=0.
- Reset mid-operation:
  - rst in any state returns to IDLE, clears all valid bits, and zeroes the counter.
  - Any partially refilled line stays invalid.
  - mem_resp_valid is ignored outside REFILL_DATA; the memory is reset by the same rst.
- A refill overwrites the conflicting line regardless of its prior contents; write-through means there is never dirty data.
- mem_req_* outputs are stable while valid&~ready.

Test Plan:
- Cold load 0x10000008, LINE_WORDS=4: stall rises the cycle after the request; one read request at 0x10000000. Beats 0xA0,0xA1,0xA2,0xA3 → cpu_dout=0xA2 in RESPOND with stall=0.
- Load 0x1000000C immediately after: hit, cpu_dout=0xA3 next cycle, stall never asserted, no memory request.
- Store 0xDEADBEEF mask 4'b0011 to 0x10000004 with ready=1: write request issued, zero stall. A following load of 0x10000004 returns 0x0000BEEF.
- Store to uncached line 0x10000400 with ready low 3 cycles: stall=1 for 3 cycles, request fields stable, then a load there misses (no allocate).
- Conflict: load 0x10000008, then the address with the same index and different tag (0x10000408 for LINES=64): second load misses and refills. Reloading 0x10000008 misses again.
- rst asserted after 2 of 4 refill beats: stall=0 next cycle, remaining beats ignored, and the re-presented load misses and refills fully.
